// File: rtl/mem_if_pkg.sv
// Purpose: shared types and widths for the block-level memory responder interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_if_pkg;

    localparam int BLOCK_W    = 512;
    localparam int OFFSET_W   = 6;
    localparam int DEF_IDX_W  = 8;
    localparam int CNT_W      = 4;

    // Responder FSM: idle / counting down the access latency / holding the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Request as captured at the handshake; idx is sized for the default array depth
    typedef struct packed {
        logic                 write;
        logic [DEF_IDX_W-1:0] idx;
        logic [BLOCK_W-1:0]   wdata;
    } req_t;

endpackage

// File: rtl/mem_block_array.sv
// Purpose: 2**IDX_W x BLOCK_W block storage with one write port and one registered read port.
// Latency: write lands at the enabled edge; read data is valid after the enabled edge.
// Backpressure: none; ports are strobed by the owning FSM, contents are never reset.
module mem_block_array #(
    parameter int IDX_W   = 8,
    parameter int BLOCK_W = 512
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [BLOCK_W-1:0] rd_data_o
);

    logic [BLOCK_W-1:0] mem_q [2**IDX_W];
    logic [BLOCK_W-1:0] rd_data_q;

    // Storage write and read; read data holds until the next read strobe
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_block_responder.sv
// Purpose: one-at-a-time 512-bit block refill/writeback responder in front of the block array.
// Latency: request handshake at edge N -> access and resp_valid after edge N+LATENCY.
// Backpressure: response held stable while resp_ready=0; req_ready low whenever busy.
module mem_block_responder #(
    parameter int BLOCK_W = 512,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 8,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BLOCK_W-1:0] req_wdata,
    output logic               req_ready,
    output logic               resp_valid,
    output logic               resp_write,
    output logic [BLOCK_W-1:0] resp_rdata,
    input  logic               resp_ready,
    output logic               busy
);

    import mem_if_pkg::*;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    req_t               req_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               resp_write_q;
    logic               rd_sel_q;
    logic               busy_q;

    logic               access;
    logic [BLOCK_W-1:0] arr_rdata;
    logic               unused_addr_bits;

    // Offset and bits above the index never select a block; high bits alias by design
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:OFFSET_W+IDX_W], req_addr[OFFSET_W-1:0]};

    // The access fires once the counter has drained to zero inside WAIT, which
    // places it on edge N+LATENCY for a handshake at edge N (LATENCY=1 included)
    assign access = (state_q == WAIT) && (cnt_q == '0);

    // Latency counter next state: load on handshake, count down while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && req_valid) begin
            cnt_d = CNT_W'(LATENCY - 1);
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Responder FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            rd_sel_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_q.write  <= req_write;
                        req_q.idx    <= req_addr[OFFSET_W +: IDX_W];
                        req_q.wdata  <= req_wdata;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        resp_write_q <= req_q.write;
                        rd_sel_q     <= ~req_q.write;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    // Returning to IDLE here means the next request is taken one edge later
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_write_q <= 1'b0;
                        rd_sel_q     <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    mem_block_array #(
        .IDX_W   (IDX_W),
        .BLOCK_W (BLOCK_W)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (access & req_q.write),
        .wr_idx_i  (req_q.idx),
        .wr_data_i (req_q.wdata),
        .rd_en_i   (access & ~req_q.write),
        .rd_idx_i  (req_q.idx),
        .rd_data_o (arr_rdata)
    );

    // Array read register is unreset, so gate it: zero unless answering a read
    assign resp_rdata = rd_sel_q ? arr_rdata : '0;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_write = resp_write_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_block_responder.sv
module tb_mem_block_responder;

    localparam int NI = 3;

    function automatic int lat_of(int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    typedef struct {
        bit           write;
        logic [511:0] rdata;
        time          hs_t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid  [NI];
    logic         req_write  [NI];
    logic [31:0]  req_addr   [NI];
    logic [511:0] req_wdata  [NI];
    logic         req_ready  [NI];
    logic         resp_valid [NI];
    logic         resp_write [NI];
    logic [511:0] resp_rdata [NI];
    logic         resp_ready [NI];
    logic         busy       [NI];

    exp_t         exp_q [NI][$];
    logic [511:0] model [NI][256];
    bit           known [NI][256];
    bit           rand_rdy [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        mem_block_responder #(.LATENCY(lat_of(g))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_write (resp_write[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_ready (resp_ready[g]),
            .busy       (busy[g])
        );

        // Random response backpressure when enabled
        always @(negedge clk) begin
            if (rand_rdy[g]) resp_ready[g] = 1'($urandom_range(0, 1));
        end

        // Monitor: samples 1 time unit before each rising edge
        initial begin : mon
            logic         pv;
            logic         pw;
            logic [511:0] pd;
            exp_t         e;
            int           lat;
            pv = 1'b0;
            pw = 1'b0;
            pd = '0;
            forever begin
                @(negedge clk);
                #4;
                if (rst) begin
                    pv = 1'b0;
                end else begin
                    chk("ready_vs_busy", req_ready[g], !busy[g]);
                    if (resp_valid[g] && !pv) begin
                        if (exp_q[g].size() == 0) begin
                            fail_now("unexpected_resp");
                        end else begin
                            e   = exp_q[g][0];
                            lat = int'(($time - 9 - e.hs_t) / 10);
                            chk("resp_latency", lat, lat_of(g));
                        end
                    end else if (resp_valid[g] && pv) begin
                        chk("hold_write", resp_write[g], pw);
                        chk("hold_rdata", resp_rdata[g], pd);
                    end
                    if (resp_valid[g] && resp_ready[g] && exp_q[g].size() > 0) begin
                        e = exp_q[g].pop_front();
                        chk("resp_write", resp_write[g], e.write);
                        chk("resp_rdata", resp_rdata[g], e.rdata);
                        pv = 1'b0;
                    end else begin
                        pv = resp_valid[g];
                    end
                    pw = resp_write[g];
                    pd = resp_rdata[g];
                end
            end
        end
    end

    // Issue one request (called at a negedge); returns after the handshake edge
    task automatic do_req(input int k, input bit wr, input logic [31:0] addr,
                          input logic [511:0] data, input bit commit);
        exp_t e;
        int   n;
        int   idx;
        n = 0;
        while (!req_ready[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            fail_now("req_ready_wait");
            return;
        end
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = data;
        @(posedge clk);
        e.hs_t  = $time;
        idx     = int'((addr / 64) % 256);
        e.write = wr;
        e.rdata = wr ? 512'd0 : model[k][idx];
        if (commit) begin
            if (wr) begin
                model[k][idx] = data;
                known[k][idx] = 1'b1;
            end
            exp_q[k].push_back(e);
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || busy[k]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[k].size() != 0 || busy[k]) fail_now("drain");
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [511:0] a5;
        logic [511:0] pat;
        logic [511:0] xv;
        logic [511:0] yv;
        logic [31:0]  addr;
        int           idx;
        bit           wr;

        a5 = {16{32'hA5A5_A5A5}};
        for (int w = 0; w < 16; w++) pat[w*32 +: 32] = w;
        for (int k = 0; k < NI; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
            resp_ready[k] = 1'b1;
            rand_rdy[k]   = 1'b0;
            for (int i = 0; i < 256; i++) known[k][i] = 1'b0;
        end

        // Reset values
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < NI; k++) begin
            chk("rst_req_ready", req_ready[k], 1'b1);
            chk("rst_resp_valid", resp_valid[k], 1'b0);
            chk("rst_resp_write", resp_write[k], 1'b0);
            chk("rst_resp_rdata", resp_rdata[k], 512'd0);
            chk("rst_busy", busy[k], 1'b0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back on each latency variant
        for (int k = 0; k < NI; k++) begin
            do_req(k, 1'b1, 32'h0000_0040, a5, 1'b1);
            do_req(k, 1'b0, 32'h0000_0040, '0, 1'b1);
            drain(k);
        end

        // Offset bits ignored
        do_req(0, 1'b1, 32'h0000_0080, pat, 1'b1);
        do_req(0, 1'b0, 32'h0000_0084, '0, 1'b1);
        drain(0);

        // Index aliasing above the index field
        xv = rand_blk();
        do_req(0, 1'b1, 32'h0000_0040, xv, 1'b1);
        do_req(0, 1'b0, 32'h0000_4040, '0, 1'b1);
        drain(0);

        // Held response under backpressure; a request pulse in RESP is ignored
        resp_ready[0] = 1'b0;
        do_req(0, 1'b0, 32'h0000_0080, '0, 1'b1);
        repeat (4) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk("hold_req_ready", req_ready[0], 1'b0);
            chk("hold_resp_valid", resp_valid[0], 1'b1);
            if (c == 5) begin
                req_valid[0] = 1'b1;
                req_write[0] = 1'b1;
                req_addr[0]  = 32'h0000_0080;
                req_wdata[0] = rand_blk();
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("post_accept_req_ready", req_ready[0], 1'b1);
        chk("post_accept_resp_valid", resp_valid[0], 1'b0);
        repeat (6) @(negedge clk);
        chk("no_phantom_busy", busy[0], 1'b0);
        do_req(0, 1'b0, 32'h0000_0080, '0, 1'b1);
        drain(0);

        // Reset mid-write drops the uncommitted write
        yv = rand_blk();
        do_req(0, 1'b1, 32'h0000_00C0, yv, 1'b1);
        drain(0);
        do_req(0, 1'b1, 32'h0000_00C0, ~yv, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", req_ready[0], 1'b1);
        chk("mid_rst_resp_valid", resp_valid[0], 1'b0);
        chk("mid_rst_resp_write", resp_write[0], 1'b0);
        chk("mid_rst_resp_rdata", resp_rdata[0], 512'd0);
        chk("mid_rst_busy", busy[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) exp_q[k].delete();
        @(negedge clk);
        do_req(0, 1'b0, 32'h0000_00C0, '0, 1'b1);
        drain(0);

        // Randomized traffic with random backpressure on every variant
        for (int k = 0; k < NI; k++) begin
            rand_rdy[k] = 1'b1;
            for (int n = 0; n < 40; n++) begin
                idx  = $urandom_range(0, 7);
                wr   = !known[k][idx] || ($urandom_range(0, 1) == 1);
                addr = ($urandom() & 32'hFFFF_C03F) | (32'(idx) << 6);
                do_req(k, wr, addr, rand_blk(), 1'b1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            drain(k);
            rand_rdy[k]   = 1'b0;
            resp_ready[k] = 1'b1;
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
